prog_counter: RTL and testbench
===============================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter MAX_N, default 64, the largest count length n accepted; CTR_SIZE = ceil(log2(MAX_N+1)).
REQ-002 The block SHALL have parameter PSC_MAX, default 255, the largest prescaler value; PSC_SIZE = ceil(log2(PSC_MAX+1)).
REQ-003 sys_clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  start request, sampled only in IDLE.
REQ-006 abort  in  1  cancel a run in progress, sampled only in COUNT.
REQ-007 pause  in  1  freeze counter and prescaler while high in COUNT.
REQ-008 n_val  in  CTR_SIZE  count length n, latched at accepted start.
REQ-009 psc_val  in  PSC_SIZE  prescale p, one step every p+1 clocks, latched at start.
REQ-010 mode_reload  in  1  0 = one-shot, 1 = auto-reload; latched at start.
REQ-011 mode_down  in  1  0 = count up 0..n-1, 1 = count down n-1..0; latched at start.
REQ-012 ctr_val  out  CTR_SIZE  current count.
REQ-013 busy  out  1  high while in COUNT.
REQ-014 done  out  1  level; high after reset or after one-shot completion, low otherwise.
REQ-015 wrap  out  1  one-cycle pulse on each terminal step.

Function
REQ-016 The FSM SHALL have states RESET, IDLE, COUNT; RESET is entered on rst and from any illegal encoding.
REQ-017 RESET SHALL drive ctr_val=0, done=1, busy=0, wrap=0, clear the prescaler, and go to IDLE next cycle.
REQ-018 In IDLE, start=1 with n_val!=0 SHALL latch n_val, psc_val, mode bits, set ctr_val to 0 (up) or n_val-1 (down), clear prescaler, done=0, busy=1, go to COUNT.
REQ-019 In IDLE, start=1 with n_val=0 SHALL be ignored; no output changes.
REQ-020 In COUNT, a step SHALL occur in a cycle where the prescaler equals latched p; prescaler then returns to 0, otherwise increments.
REQ-021 A non-terminal step SHALL change ctr_val by +1 (up) or -1 (down); the terminal value is n-1 (up) or 0 (down).
REQ-022 A terminal step in one-shot mode SHALL set ctr_val=0, done=1, busy=0, wrap=1 for one cycle, go to IDLE.
REQ-023 A terminal step in reload mode SHALL reload ctr_val to its start value, pulse wrap, stay in COUNT with busy=1.
REQ-024 A one-shot run SHALL keep busy high for exactly n*(p+1) cycles; each count value, including the terminal one, is held p+1 cycles.
REQ-025 pause=1 in COUNT SHALL hold ctr_val and prescaler unchanged and suppress wrap.
REQ-026 abort=1 in COUNT SHALL set ctr_val=0, busy=0, done=0, wrap=0, go to IDLE next cycle; abort beats pause and a coincident terminal step.
REQ-027 start in COUNT and abort/pause in IDLE SHALL be ignored; n_val/psc_val/mode changes during COUNT SHALL have no effect.
REQ-028 ctr_val arithmetic SHALL be CTR_SIZE-bit unsigned, never leaving 0..n-1.

Reset
REQ-029 rst=1 SHALL take priority over all inputs; while asserted: ctr_val=0, busy=0, done=0, wrap=0; first cycle after release goes through RESET, so done=1 one cycle later.
REQ-030 rst mid-run SHALL discard the run; no wrap pulse is issued.

Verification
REQ-031 Up one-shot n=4,p=0: start at T -> ctr_val 0,1,2,3 on T+1..T+4; T+5 ctr_val=0, done=1, wrap=1, busy=0.
REQ-032 Down one-shot n=3,p=2: -> ctr_val 2,1,0 each held 3 cycles; busy high 9 cycles; single wrap pulse.
REQ-033 Up reload n=2,p=0 for 10 cycles -> ctr_val alternates 0,1; wrap every 2nd cycle; busy stays 1; abort -> busy=0, done=0, ctr_val=0.
REQ-034 n=5,p=1, pause held 4 cycles mid-run -> ctr_val frozen, busy duration extends to 14 cycles.
REQ-035 start with n_val=0 -> no change; abort coincident with terminal step -> done=0, no wrap.
REQ-036 rst during COUNT at ctr_val=3 -> outputs 0 while asserted; done=1 one cycle after release; new start accepted.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: programmable prescaled up/down counter with one-shot and
// auto-reload modes.
//
// A run is launched from IDLE by start with a non-zero length n. The counter
// then walks 0..n-1 (up) or n-1..0 (down), advancing one value every p+1
// clocks. Reaching the terminal value either finishes the run (one-shot) or
// reloads the start value (auto-reload). Every terminal step raises wrap for
// one cycle. All outputs are registered.
//
// Parameters:
//   MAX_N    largest count length accepted (sets CTR_SIZE)
//   PSC_MAX  largest prescaler value (sets PSC_SIZE)
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   launch a run (looked at only in IDLE)
//   abort        in   cancel the current run (looked at only in COUNT)
//   pause        in   freeze counter and prescaler while high in COUNT
//   n_val        in   count length n, captured at launch
//   psc_val      in   prescale p, one step every p+1 clocks, captured at launch
//   mode_reload  in   0 = one-shot, 1 = auto-reload, captured at launch
//   mode_down    in   0 = count up, 1 = count down, captured at launch
//   ctr_val      out  current count
//   busy         out  high while a run is in progress
//   done         out  high after reset or after a one-shot run completes
//   wrap         out  one-cycle pulse on each terminal step

module prog_counter #(
  parameter int MAX_N   = 64,
  parameter int PSC_MAX = 255,
  localparam int CTR_SIZE = $clog2(MAX_N + 1),
  localparam int PSC_SIZE = $clog2(PSC_MAX + 1)
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  input  logic [CTR_SIZE-1:0] n_val,
  input  logic [PSC_SIZE-1:0] psc_val,
  input  logic                mode_reload,
  input  logic                mode_down,
  output logic [CTR_SIZE-1:0] ctr_val,
  output logic                busy,
  output logic                done,
  output logic                wrap
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  logic [1:0]          state;
  logic [CTR_SIZE-1:0] n_lat;
  logic [PSC_SIZE-1:0] p_lat;
  logic                reload_lat;
  logic                down_lat;
  logic [PSC_SIZE-1:0] psc_cnt;

  logic                step;
  logic                terminal;
  logic [CTR_SIZE-1:0] start_val;
  logic [CTR_SIZE-1:0] next_val;

  // Step/terminal decode for the running count. The terminal value is the
  // last one a run visits: n-1 counting up, 0 counting down. start_val is
  // where a run begins and where auto-reload returns to.
  always_comb begin
    step      = (psc_cnt == p_lat);
    start_val = down_lat ? (n_lat - 1'b1) : '0;
    terminal  = down_lat ? (ctr_val == '0) : (ctr_val == (n_lat - 1'b1));
    next_val  = down_lat ? (ctr_val - 1'b1) : (ctr_val + 1'b1);
  end

  // Main control. rst forces every output low and parks the FSM in RESET;
  // the first un-reset cycle passes through RESET, which raises done and
  // moves to IDLE. An illegal state encoding is treated like a reset.
  // Inside COUNT, abort wins over pause and over any step in that cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= ST_RESET;
      ctr_val    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap       <= 1'b0;
      psc_cnt    <= '0;
      n_lat      <= '0;
      p_lat      <= '0;
      reload_lat <= 1'b0;
      down_lat   <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          ctr_val <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          wrap    <= 1'b0;
          psc_cnt <= '0;
          state   <= ST_IDLE;
        end

        ST_IDLE: begin
          wrap <= 1'b0;
          if (start && (n_val != '0)) begin
            n_lat      <= n_val;
            p_lat      <= psc_val;
            reload_lat <= mode_reload;
            down_lat   <= mode_down;
            ctr_val    <= mode_down ? (n_val - 1'b1) : '0;
            psc_cnt    <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          wrap <= 1'b0;
          if (abort) begin
            ctr_val <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            psc_cnt <= '0;
            state   <= ST_IDLE;
          end else if (!pause) begin
            if (step) begin
              psc_cnt <= '0;
              if (terminal) begin
                wrap <= 1'b1;
                if (reload_lat) begin
                  ctr_val <= start_val;
                end else begin
                  ctr_val <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_IDLE;
                end
              end else begin
                ctr_val <= next_val;
              end
            end else begin
              psc_cnt <= psc_cnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_RESET;
          ctr_val <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          wrap    <= 1'b0;
          psc_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: scoreboard bench for prog_counter.
//
// The driver applies one set of inputs per cycle on the falling edge and
// asks a behavioural model what the outputs must be after the next rising
// edge; that expectation is queued. A separate monitor samples the DUT just
// after each rising edge and compares against the oldest queued entry.
//
// The model tracks a run as "active cycles elapsed" k: the step count is
// k/(p+1), the position within the sequence is that count modulo n, and a
// terminal step is one where the position returns to zero.

module tb_prog_counter;

  localparam int MAX_N    = 64;
  localparam int PSC_MAX  = 255;
  localparam int CTR_SIZE = $clog2(MAX_N + 1);
  localparam int PSC_SIZE = $clog2(PSC_MAX + 1);

  logic                sys_clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic                pause;
  logic [CTR_SIZE-1:0] n_val;
  logic [PSC_SIZE-1:0] psc_val;
  logic                mode_reload;
  logic                mode_down;
  logic [CTR_SIZE-1:0] ctr_val;
  logic                busy;
  logic                done;
  logic                wrap;

  always #5 sys_clk = ~sys_clk;

  prog_counter #(
    .MAX_N   (MAX_N),
    .PSC_MAX (PSC_MAX)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .n_val       (n_val),
    .psc_val     (psc_val),
    .mode_reload (mode_reload),
    .mode_down   (mode_down),
    .ctr_val     (ctr_val),
    .busy        (busy),
    .done        (done),
    .wrap        (wrap)
  );

  typedef struct packed {
    logic [CTR_SIZE-1:0] ctr;
    logic                busy;
    logic                done;
    logic                wrap;
  } exp_t;

  typedef enum {M_RESET, M_IDLE, M_RUN} phase_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;

  phase_t m_phase  = M_RESET;
  int     m_n      = 1;
  int     m_p      = 0;
  int     m_k      = 0;
  logic   m_reload = 1'b0;
  logic   m_down   = 1'b0;
  exp_t   m_out    = '0;

  // Value shown at position i of a run's sequence.
  function automatic int run_value(input int i);
    return m_down ? (m_n - 1 - i) : i;
  endfunction

  // Reference model: outputs expected after the next rising edge.
  task automatic model_step(input logic s, input logic a, input logic pa,
                            input int n, input int p,
                            input logic rl, input logic dn, input logic r);
    int steps;
    int idx;
    m_out.wrap = 1'b0;
    if (r) begin
      m_phase = M_RESET;
      m_out   = '0;
    end else begin
      case (m_phase)
        M_RESET: begin
          m_out.ctr  = '0;
          m_out.busy = 1'b0;
          m_out.done = 1'b1;
          m_phase    = M_IDLE;
        end
        M_IDLE: begin
          if (s && (n != 0)) begin
            m_n        = n;
            m_p        = p;
            m_reload   = rl;
            m_down     = dn;
            m_k        = 0;
            m_out.ctr  = CTR_SIZE'(run_value(0));
            m_out.busy = 1'b1;
            m_out.done = 1'b0;
            m_phase    = M_RUN;
          end
        end
        M_RUN: begin
          if (a) begin
            m_out   = '0;
            m_phase = M_IDLE;
          end else if (!pa) begin
            m_k++;
            if ((m_k % (m_p + 1)) == 0) begin
              steps = m_k / (m_p + 1);
              idx   = steps % m_n;
              if (idx == 0) begin
                m_out.wrap = 1'b1;
                if (!m_reload) begin
                  m_out.ctr  = '0;
                  m_out.busy = 1'b0;
                  m_out.done = 1'b1;
                  m_phase    = M_IDLE;
                end else begin
                  m_out.ctr = CTR_SIZE'(run_value(0));
                end
              end else begin
                m_out.ctr = CTR_SIZE'(run_value(idx));
              end
            end
          end
        end
        default: m_phase = M_RESET;
      endcase
    end
    exp_q.push_back(m_out);
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic apply_stimulus(input logic s, input logic a, input logic pa,
                                input int n, input int p,
                                input logic rl, input logic dn, input logic r);
    @(negedge sys_clk);
    rst         = r;
    start       = s;
    abort       = a;
    pause       = pa;
    n_val       = CTR_SIZE'(n);
    psc_val     = PSC_SIZE'(p);
    mode_reload = rl;
    mode_down   = dn;
    model_step(s, a, pa, n, p, rl, dn, r);
    cycle++;
  endtask

  // Quiet cycles; configuration inputs are scrambled to show they are ignored.
  task automatic hold_cycles(input int cnt);
    for (int i = 0; i < cnt; i++)
      apply_stimulus(1'b0, 1'b0, 1'b0, $urandom_range(0, 9), $urandom_range(0, 5),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic launch(input int n, input int p, input logic rl, input logic dn);
    apply_stimulus(1'b1, 1'b0, 1'b0, n, p, rl, dn, 1'b0);
  endtask

  task automatic check_output();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    if ({ctr_val, busy, done, wrap} !== e) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t: got ctr=%0d busy=%0b done=%0b wrap=%0b, expected ctr=%0d busy=%0b done=%0b wrap=%0b",
               $time, ctr_val, busy, done, wrap, e.ctr, e.busy, e.done, e.wrap);
    end
  endtask

  // Monitor: compare one queued expectation just after every rising edge.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) check_output();
    end
  end

  // Stimulus: directed scenarios first, then a randomized soak.
  initial begin
    int    n;
    int    p;
    logic  r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    n_val = '0; psc_val = '0; mode_reload = 1'b0; mode_down = 1'b0;

    $display("[TB] reset");
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1);
    hold_cycles(3);

    $display("[TB] up one-shot n=4 p=0");
    launch(4, 0, 1'b0, 1'b0);
    hold_cycles(7);

    $display("[TB] down one-shot n=3 p=2");
    launch(3, 2, 1'b0, 1'b1);
    hold_cycles(12);

    $display("[TB] up reload n=2 p=0, start ignored mid-run, then abort");
    launch(2, 0, 1'b1, 1'b0);
    hold_cycles(5);
    launch(7, 3, 1'b0, 1'b1);
    hold_cycles(4);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    hold_cycles(3);

    $display("[TB] n=5 p=1 with a 4-cycle pause");
    launch(5, 1, 1'b0, 1'b0);
    hold_cycles(3);
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    hold_cycles(12);

    $display("[TB] start with n=0, abort/pause in IDLE");
    launch(0, 0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    hold_cycles(2);

    $display("[TB] abort on terminal step");
    launch(3, 0, 1'b0, 1'b0);
    hold_cycles(2);
    apply_stimulus(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    hold_cycles(3);

    $display("[TB] reset mid-run at ctr=3, then restart");
    launch(6, 0, 1'b0, 1'b0);
    hold_cycles(3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    hold_cycles(2);
    launch(2, 1, 1'b0, 1'b1);
    hold_cycles(6);

    $display("[TB] boundaries: n=MAX_N up, n=1 down reload");
    launch(MAX_N, 0, 1'b0, 1'b0);
    hold_cycles(MAX_N + 2);
    launch(1, 1, 1'b1, 1'b1);
    hold_cycles(7);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    hold_cycles(2);

    $display("[TB] randomized soak");
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 149) == 0);
      n = ($urandom_range(0, 19) == 0) ? $urandom_range(0, MAX_N) : $urandom_range(0, 6);
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3);
      apply_stimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 7) == 0), n, p,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
    end

    @(posedge sys_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
